serial_neuron_acc: RTL and testbench
====================================

Name: serial_neuron_acc

Overview:
Bit-serial neuron accumulator. It sits directly downstream of the s2 logic-module datapath and consumes the registered single-bit output stream from that datapath. For each of NIN inputs it deserialises one unsigned activation (LSB first), multiplies it by a signed weight and accumulates it onto a bias. The result then passes through ReLU and unsigned saturation, and is presented on a valid/ready output port.

Parameters:
- DW, 8: activation and result width in bits; serial bits per input.
- WW, 8: signed weight width.
- NIN, 4: number of inputs per neuron evaluation (>=1).
- AW, 20: signed accumulator width; must be >= DW+WW+clog2(NIN)+2.

Ports:
- clk, in, 1: single clock, rising edge.
- clr, in, 1: reset, asynchronous, active-low.
- start, in, 1: begin an evaluation; sampled only in IDLE.
- x_bit, in, 1: serial activation bit from the registered s2 output, LSB first.
- w, in, WW: signed weight for input w_idx; sampled in the MAC cycle.
- bias, in, AW: signed bias; sampled with start.
- w_idx, out, clog2(NIN) (min 1): index of the input currently being processed.
- busy, out, 1: high in SHIFT, MAC and DONE.
- out_valid, out, 1: result available.
- out_ready, in, 1: consumer accepts the result.
- y, out, DW: ReLU'd, saturated result.
- sat, out, 1: y was clipped at the upper bound.

Behaviour:
- Reset (clr=0, async): state=IDLE; acc, shift register, bit_cnt, w_idx, y, sat, out_valid and busy all cleared to 0. This applies in any state, including mid-evaluation; a partial result is discarded and never emitted.
- States: IDLE, SHIFT, MAC, DONE.
- IDLE, start=1 at edge E0: acc<=sign-extended bias, w_idx<=0, bit_cnt<=0, go to SHIFT.
- SHIFT:
  - Each edge shifts x_bit into the MSB of a DW-bit shift register (right shift), so after DW edges bit0 is the first bit received.
  - After the DW-th sample (bit_cnt==DW-1), go to MAC.
- MAC (exactly 1 cycle):
  - acc <= acc + ($signed({1'b0,xreg}) * $signed(w)), full-precision product, sign-extended to AW.
  - If w_idx==NIN-1, go to DONE. Otherwise w_idx++, bit_cnt<=0, go to SHIFT.
- Timing:
  - Each input takes DW+1 cycles.
  - The final MAC happens at edge E0+NIN*(DW+1).
  - out_valid is high from that edge onward, i.e. in cycle NIN*(DW+1)+1 counted from the start edge.
- On entry to DONE, y and sat are registered:
  - acc<0: y=0, sat=0.
  - acc>2^DW-1: y=all ones, sat=1.
  - Otherwise: y=acc[DW-1:0], sat=0.
- DONE:
  - out_valid=1; y and sat are held stable until the handshake.
  - out_valid && out_ready at an edge: go to IDLE; out_valid and busy are 0 after that edge. y and sat hold their last value.
- start is ignored whenever state != IDLE, including DONE and the handshake cycle; no queuing.
- No overflow inside acc, given the AW constraint and |bias| < 2^(AW-2). Overflow outside that range is unspecified.
- w_idx is valid while busy. Upstream must present the weight for w_idx no later than the MAC cycle.

Decomposition:
- Shared package (neuron_pkg):
  - State encoding localparams (IDLE=2'd0, SHIFT=2'd1, MAC=2'd2, DONE=2'd3).
  - relu_sat function (AW in, DW+1 out {sat,y}).
  - clog2 helper.
- One sub-module: sipo_shift, a DW-bit serial-in/parallel-out register with an enable and async active-low clear. It is reusable by other serial stages fed from s2 cells.
- The FSM, accumulator and output register stay in serial_neuron_acc.

Test Plan:
1. Reset mid-SHIFT (DW=8, NIN=4): assert clr=0 at cycle 5 after start -> all outputs 0 immediately (async), state IDLE. After release, a fresh start behaves normally.
2. x={3,5,7,9}, w={1,2,-1,1}, bias=0 -> y=15, sat=0. out_valid rises exactly at cycle 37 after start; w_idx steps 0,1,2,3, each held 9 cycles.
3. x={10,0,0,0}, w={-3,4,4,4}, bias=5 -> acc=-25 -> y=0, sat=0.
4. x all 255, w all 127, bias=0 -> acc=129540 -> y=255, sat=1. Then bias=-129285 with the same inputs -> acc=255 -> y=255, sat=0 (boundary).
5. Backpressure: hold out_ready=0 for 10 cycles after out_valid, pulsing start throughout -> y, sat, out_valid stable; no restart. Raise out_ready for 1 cycle -> next cycle out_valid=0, busy=0.
6. Back-to-back: start asserted in the cycle immediately after the handshake -> second evaluation completes 37 cycles later with the correct independent result; the first result is not disturbed before its handshake.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared types and helpers for the bit-serial neuron datapath: state encoding,
// width helper and the ReLU/saturation stage applied to the final accumulator.
package neuron_pkg;

  localparam int N_DW  = 8;
  localparam int N_WW  = 8;
  localparam int N_NIN = 4;
  localparam int N_AW  = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    MAC   = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  localparam logic signed [N_AW-1:0] Y_MAX = N_AW'((1 << N_DW) - 1);

  // Returns {sat, y}: negative clamps to zero, anything above 2^DW-1 clips high.
  function automatic logic [N_DW:0] relu_sat(input logic signed [N_AW-1:0] acc);
    if (acc < 0)
      return '0;
    else if (acc > Y_MAX)
      return {1'b1, {N_DW{1'b1}}};
    else
      return {1'b0, acc[N_DW-1:0]};
  endfunction

endpackage

// File: rtl/sipo_shift.sv
// Serial-in/parallel-out register fed LSB first; after W enabled edges bit 0
// holds the first bit received.
module sipo_shift #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en_i,
  input  logic         bit_i,
  output logic [W-1:0] data_o
);

  logic [W-1:0] data_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr)
      data_q <= '0;
    else if (en_i)
      data_q <= {bit_i, data_q[W-1:1]};
  end

  assign data_o = data_q;

endmodule

// File: rtl/serial_neuron_acc.sv
// Bit-serial neuron: deserialises NIN activations, accumulates activation*weight
// onto a bias, then applies ReLU and unsigned saturation behind a valid/ready port.
module serial_neuron_acc
  import neuron_pkg::*;
#(
  parameter int DW  = N_DW,
  parameter int WW  = N_WW,
  parameter int NIN = N_NIN,
  parameter int AW  = N_AW,
  localparam int IW = (NIN > 1) ? clog2(NIN) : 1
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  input  logic          x_bit,
  input  logic [WW-1:0] w,
  input  logic [AW-1:0] bias,
  output logic [IW-1:0] w_idx,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] y,
  output logic          sat
);

  localparam int CW = (DW > 1) ? clog2(DW) : 1;

  state_t                state_q;
  logic signed [AW-1:0]  acc_q;
  logic [CW-1:0]         bit_cnt_q;
  logic [IW-1:0]         w_idx_q;
  logic                  busy_q;
  logic                  valid_q;
  logic [DW-1:0]         y_q;
  logic                  sat_q;

  logic [DW-1:0]         xreg;
  logic signed [DW+WW:0] prod;
  logic signed [AW-1:0]  acc_d;
  logic [DW:0]           res_d;

  sipo_shift #(.W(DW)) u_sipo (
    .clk    (clk),
    .clr    (clr),
    .en_i   (state_q == SHIFT),
    .bit_i  (x_bit),
    .data_o (xreg)
  );

  // Activation is unsigned, so a zero MSB is prepended before the signed multiply.
  assign prod  = $signed({1'b0, xreg}) * $signed(w);
  assign acc_d = acc_q + $signed({{(AW-DW-WW-1){prod[DW+WW]}}, prod});
  assign res_d = relu_sat(acc_d);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      bit_cnt_q <= '0;
      w_idx_q   <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      y_q       <= '0;
      sat_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            acc_q     <= bias;
            w_idx_q   <= '0;
            bit_cnt_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          bit_cnt_q <= bit_cnt_q + CW'(1);
          if (bit_cnt_q == CW'(DW - 1))
            state_q <= MAC;
        end
        MAC: begin
          acc_q <= acc_d;
          if (w_idx_q == IW'(NIN - 1)) begin
            valid_q <= 1'b1;
            sat_q   <= res_d[DW];
            y_q     <= res_d[DW-1:0];
            state_q <= DONE;
          end else begin
            w_idx_q   <= w_idx_q + IW'(1);
            bit_cnt_q <= '0;
            state_q   <= SHIFT;
          end
        end
        DONE: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign w_idx     = w_idx_q;
  assign busy      = busy_q;
  assign out_valid = valid_q;
  assign y         = y_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_serial_neuron_acc.sv
// Directed bench for serial_neuron_acc: stimulus pushes expected {sat,y} into a
// scoreboard, a separate monitor pops and compares on each output handshake.
module tb_serial_neuron_acc;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic        x_bit;
  logic [7:0]  w;
  logic [19:0] bias;
  logic [1:0]  w_idx;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  y;
  logic        sat;

  int n_vec  = 0;
  int n_miss = 0;
  int n_txn  = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  serial_neuron_acc dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .x_bit     (x_bit),
    .w         (w),
    .bias      (bias),
    .w_idx     (w_idx),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .sat       (sat)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: samples mid-cycle, after the stimulus has settled at the falling edge.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_txn++;
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          $display("txn %0d: y=%0d sat=%0d expected y=%0d sat=%0d", n_txn, y, sat, e[7:0], e[8]);
          chk("result_y", 32'(y), 32'(e[7:0]));
          chk("result_sat", 32'(sat), 32'(e[8]));
        end
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Called at a falling edge with the DUT idle; returns at the falling edge
  // right after the final MAC edge.
  task automatic run_eval(input logic [31:0] xv, input logic [31:0] wv, input int b,
                          input logic [8:0] expv);
    logic [7:0] xb;
    exp_q.push_back(expv);
    start = 1'b1;
    bias  = 20'(b);
    for (int i = 0; i < 4; i++) begin
      xb = xv[i*8 +: 8];
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        start = (k == 3);
        chk("w_idx_shift", 32'(w_idx), 32'(i));
        chk("busy_shift", 32'(busy), 32'd1);
        x_bit = xb[k];
        w     = 8'h5A;
      end
      @(negedge clk);
      chk("w_idx_mac", 32'(w_idx), 32'(i));
      chk("valid_early", 32'(out_valid), 32'd0);
      w     = wv[i*8 +: 8];
      x_bit = 1'b0;
    end
    @(negedge clk);
    start = 1'b0;
    chk("valid_rise", 32'(out_valid), 32'd1);
    chk("busy_done", 32'(busy), 32'd1);
  endtask

  // Holds out_ready low for 'hold' cycles while pulsing start, then handshakes.
  task automatic handshake(input int hold, input logic [8:0] expv);
    for (int k = 0; k < hold; k++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_y", 32'(y), 32'(expv[7:0]));
      chk("bp_sat", 32'(sat), 32'(expv[8]));
      out_ready = 1'b0;
      start     = ~start;
      @(negedge clk);
    end
    out_ready = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b0;
    chk("post_hs_valid", 32'(out_valid), 32'd0);
    chk("post_hs_busy", 32'(busy), 32'd0);
    chk("post_hs_y", 32'(y), 32'(expv[7:0]));
  endtask

  initial begin
    clr = 1'b0; start = 1'b0; x_bit = 1'b0; w = '0; bias = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_widx", 32'(w_idx), 32'd0);
    clr = 1'b1;
    @(negedge clk);

    // 3+10-7+9 = 15
    run_eval(32'h09070503, 32'h01FF0201, 0, 9'h00F);
    handshake(0, 9'h00F);

    // Asynchronous clear mid-SHIFT; the partial result must never appear.
    start = 1'b1;
    repeat (5) begin
      @(negedge clk);
      start = 1'b0;
      x_bit = 1'b1;
    end
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 clr = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_y", 32'(y), 32'd0);
    chk("arst_sat", 32'(sat), 32'd0);
    chk("arst_widx", 32'(w_idx), 32'd0);
    @(negedge clk);
    clr = 1'b1;
    x_bit = 1'b0;
    @(negedge clk);

    // 10*-3 + 5 = -25 -> ReLU to 0
    run_eval(32'h0000000A, 32'h040404FD, 5, 9'h000);
    handshake(0, 9'h000);

    // 4*255*127 = 129540 -> saturates, with backpressure and start pulses
    run_eval(32'hFFFFFFFF, 32'h7F7F7F7F, 0, 9'h1FF);
    handshake(10, 9'h1FF);

    // Back-to-back: 129540-129285 = 255 exactly, not flagged
    run_eval(32'hFFFFFFFF, 32'h7F7F7F7F, -129285, 9'h0FF);
    handshake(3, 9'h0FF);

    // 20 - (1+2+3+4) = 10
    run_eval(32'h04030201, 32'hFFFFFFFF, 20, 9'h00A);
    handshake(0, 9'h00A);

    // Zero activations, bias 256 -> one above the limit
    run_eval(32'h00000000, 32'h7F7F7F7F, 256, 9'h1FF);
    handshake(0, 9'h1FF);

    // -1 just below zero
    run_eval(32'h00000001, 32'h000000FF, 0, 9'h000);
    handshake(0, 9'h000);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    chk("txn_count", 32'(n_txn), 32'd7);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
